// File: rtl/muldiv_pkg.sv
// muldiv_pkg
// Shared definitions for the multiply/divide controller and its datapath
// helpers: op encoding, controller state enum, divider step count, the
// quotient reported for a zero divisor, and a small magnitude helper.
// Optional feature macro used by the files that import this package:
//   MULDIV_DIV_EN - when defined, the sequential signed divider is built.
package muldiv_pkg;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  localparam int DIV_STEPS = 32;

  localparam logic [31:0] DIVZ_QUOT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE,
    MUL_WAIT,
    DIV_RUN,
    DIV_FIX
  } state_t;

  // Two's-complement magnitude. 0x80000000 maps to itself, which is the
  // correct unsigned magnitude 2^31.
  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/div32_seq.sv
// div32_seq
// Unsigned 32-bit restoring divider iteration datapath: remainder/quotient
// shift registers and the step counter. Signs are handled by the caller.
// Only built when MULDIV_DIV_EN is defined.
// Ports:
//   clock             in  - rising-edge clock
//   clear_n           in  - asynchronous active-low reset
//   load              in  - capture new magnitudes and arm DIV_STEPS steps
//   dividend [31:0]   in  - dividend magnitude
//   divisor  [31:0]   in  - divisor magnitude (non-zero)
//   quotient [31:0]   out - quotient magnitude (valid after the last step)
//   remainder[31:0]   out - remainder magnitude (valid after the last step)
//   last              out - the step taken on the next edge is the final one
`ifdef MULDIV_DIV_EN
module div32_seq
  import muldiv_pkg::*;
(
  input  logic        clock,
  input  logic        clear_n,
  input  logic        load,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        last
);

  logic [31:0] rem_q;
  logic [31:0] quot_q;
  logic [31:0] dvsr_q;
  logic [5:0]  count_q;
  logic [32:0] shifted;
  logic [32:0] trial;

  // The remainder is always below the divisor (at most 2^31), so after the
  // shift it fits in 32 bits; the extra bit only carries the trial sign.
  always_comb begin
    shifted = {rem_q, quot_q[31]};
    trial   = shifted - {1'b0, dvsr_q};
  end

  // One restoring step per cycle while the counter is non-zero. The
  // dividend is shifted out of the quotient register as quotient bits
  // are shifted in.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      rem_q   <= '0;
      quot_q  <= '0;
      dvsr_q  <= '0;
      count_q <= '0;
    end else if (load) begin
      rem_q   <= '0;
      quot_q  <= dividend;
      dvsr_q  <= divisor;
      count_q <= 6'(DIV_STEPS);
    end else if (count_q != '0) begin
      count_q <= count_q - 6'd1;
      if (!trial[32]) begin
        rem_q  <= trial[31:0];
        quot_q <= {quot_q[30:0], 1'b1};
      end else begin
        rem_q  <= shifted[31:0];
        quot_q <= {quot_q[30:0], 1'b0};
      end
    end
  end

  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign last      = (count_q == 6'd1);

endmodule
`endif

// File: rtl/mul32.sv
// mul32
// Combinational signed 32x32 -> 64 radix-4 Booth multiplier.
// Ports:
//   a [31:0] in  - signed multiplicand
//   b [31:0] in  - signed multiplier
//   p [63:0] out - signed product
module mul32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] p
);

  logic [63:0] acc;
  logic [63:0] mcand;
  logic [32:0] bext;
  logic [2:0]  grp;

  // Radix-4 Booth recoding: each overlapping 3-bit group of the multiplier
  // (with an implicit 0 below bit 0) selects 0, +-1x or +-2x the sign-extended
  // multiplicand, weighted by 4^i. Sixteen groups cover a signed 32-bit b.
  always_comb begin
    acc   = '0;
    grp   = '0;
    mcand = {{32{a[31]}}, a};
    bext  = {b, 1'b0};
    for (int i = 0; i < 16; i++) begin
      grp = bext[2*i +: 3];
      case (grp)
        3'b001, 3'b010: acc = acc + (mcand << (2*i));
        3'b011:         acc = acc + (mcand << (2*i + 1));
        3'b100:         acc = acc - (mcand << (2*i + 1));
        3'b101, 3'b110: acc = acc - (mcand << (2*i));
        default:        acc = acc;
      endcase
    end
    p = acc;
  end

endmodule

// File: rtl/muldiv_hilo.sv
// muldiv_hilo
// Sequential multiply/divide controller owning the HI/LO result registers.
// MUL drives registered operands into mul32 and writes the product after
// MUL_LAT cycles; DIV (when MULDIV_DIV_EN is defined) runs a 32-step signed
// divide through div32_seq and applies the sign fixup here. Without
// MULDIV_DIV_EN a DIV completes after one cycle, leaves HI/LO alone and
// raises div_zero to flag the unsupported op.
// Ports:
//   clock          in  - rising-edge clock
//   clear_n        in  - asynchronous active-low reset
//   start          in  - request, sampled only while idle
//   op             in  - OP_MUL / OP_DIV
//   a, b [31:0]    in  - multiplicand/dividend, multiplier/divisor
//   hi_wr, lo_wr   in  - direct HI/LO writes (mthi/mtlo)
//   wr_data [31:0] in  - data for hi_wr/lo_wr
//   busy           out - operation in flight
//   done           out - one-cycle completion pulse
//   div_zero       out - sticky zero-divisor / unsupported-op flag
//   hi, lo [31:0]  out - HI/LO registers
module muldiv_hilo
  import muldiv_pkg::*;
#(
  parameter int MUL_LAT = 2
) (
  input  logic        clock,
  input  logic        clear_n,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hi_wr,
  input  logic        lo_wr,
  input  logic [31:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [1:0] CNT_INIT = 2'(MUL_LAT - 1);

  state_t      state;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [1:0]  cnt;
  logic [63:0] prod;

  mul32 u_mul (
    .a(a_q),
    .b(b_q),
    .p(prod)
  );

`ifdef MULDIV_DIV_EN
  logic        qneg;
  logic        rneg;
  logic        zflag;
  logic        div_load;
  logic        div_last;
  logic [31:0] quot_mag;
  logic [31:0] rem_mag;

  // The divider captures magnitudes straight from the input buses on the
  // accepting edge, so it starts iterating on the very next edge.
  assign div_load = (state == IDLE) && start && (op == OP_DIV) && (b != '0);

  div32_seq u_div (
    .clock    (clock),
    .clear_n  (clear_n),
    .load     (div_load),
    .dividend (abs32(a)),
    .divisor  (abs32(b)),
    .quotient (quot_mag),
    .remainder(rem_mag),
    .last     (div_last)
  );
`endif

  // Controller FSM. Direct HI/LO writes are applied first so that a
  // completion write issued on the same edge takes precedence.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state    <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
`ifdef MULDIV_DIV_EN
      qneg     <= 1'b0;
      rneg     <= 1'b0;
      zflag    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (hi_wr) hi <= wr_data;
      if (lo_wr) lo <= wr_data;

      case (state)
        IDLE: begin
          if (start) begin
            a_q      <= a;
            b_q      <= b;
            div_zero <= 1'b0;
            busy     <= 1'b1;
            if (op == OP_MUL) begin
              cnt   <= CNT_INIT;
              state <= MUL_WAIT;
            end else begin
`ifdef MULDIV_DIV_EN
              qneg  <= a[31] ^ b[31];
              rneg  <= a[31];
              zflag <= (b == '0);
              state <= (b == '0) ? DIV_FIX : DIV_RUN;
`else
              state <= DIV_FIX;
`endif
            end
          end
        end

        MUL_WAIT: begin
          if (cnt == '0) begin
            hi    <= prod[63:32];
            lo    <= prod[31:0];
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end

`ifdef MULDIV_DIV_EN
        DIV_RUN: begin
          if (div_last) state <= DIV_FIX;
        end
`endif

        // Magnitude negation wraps 0x80000000 / -1 back to 0x80000000.
        DIV_FIX: begin
`ifdef MULDIV_DIV_EN
          if (zflag) begin
            hi       <= a_q;
            lo       <= DIVZ_QUOT;
            div_zero <= 1'b1;
          end else begin
            lo <= qneg ? (32'd0 - quot_mag) : quot_mag;
            hi <= rneg ? (32'd0 - rem_mag) : rem_mag;
          end
`else
          div_zero <= 1'b1;
`endif
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_hilo.sv
// tb_muldiv_hilo
// Scoreboard bench for muldiv_hilo. Issued operations push their expected
// HI/LO/div_zero and completion cycle into a queue; a monitor pops and
// compares on every done pulse. Expected results come from plain signed
// arithmetic on the operands. Follows MULDIV_DIV_EN like the design.
`timescale 1ns/1ps
module tb_muldiv_hilo;
  import muldiv_pkg::*;

  localparam int MUL_LAT  = 2;
  localparam int MAX_WAIT = 200;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          due;
    int          tag;
  } exp_t;

  logic        clock = 1'b0;
  logic        clear_n = 1'b0;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        hi_wr = 1'b0;
  logic        lo_wr = 1'b0;
  logic [31:0] wr_data = '0;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  int          op_tag = 0;
  exp_t        sbq[$];
  exp_t        mon_e;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  muldiv_hilo #(.MUL_LAT(MUL_LAT)) dut (
    .clock   (clock),
    .clear_n (clear_n),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .hi_wr   (hi_wr),
    .lo_wr   (lo_wr),
    .wr_data (wr_data),
    .busy    (busy),
    .done    (done),
    .div_zero(div_zero),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, expv);
    end
  endtask

  // Reference behaviour: results straight from signed arithmetic.
  task automatic predict(input logic opv, input logic [31:0] av, input logic [31:0] bv, output exp_t e);
    logic signed [63:0] sa, sb, prod;
    int lat;
    e.dz = 1'b0;
    if (opv == OP_MUL) begin
      sa   = {{32{av[31]}}, av};
      sb   = {{32{bv[31]}}, bv};
      prod = sa * sb;
      e.hi = prod[63:32];
      e.lo = prod[31:0];
      lat  = MUL_LAT;
    end else begin
`ifdef MULDIV_DIV_EN
      if (bv == 32'd0) begin
        e.hi = av;
        e.lo = 32'hFFFF_FFFF;
        e.dz = 1'b1;
        lat  = 1;
      end else if (av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) begin
        e.hi = 32'd0;
        e.lo = 32'h8000_0000;
        lat  = 33;
      end else begin
        e.lo = 32'($signed(av) / $signed(bv));
        e.hi = 32'($signed(av) % $signed(bv));
        lat  = 33;
      end
`else
      e.hi = m_hi;
      e.lo = m_lo;
      e.dz = 1'b1;
      lat  = 1;
`endif
    end
    e.due = cyc + 1 + lat;
    e.tag = op_tag;
    m_hi  = e.hi;
    m_lo  = e.lo;
  endtask

  task automatic waitIdle(input string name);
    int w = 0;
    while (busy && w < MAX_WAIT) begin
      @(negedge clock);
      w++;
    end
    checkOutput({name, "_idle_timeout"}, {31'd0, busy}, 32'd0);
  endtask

  // Issue one operation at a negedge; returns on the negedge after the
  // accepting edge, with operand inputs scrambled.
  task automatic applyStimulus(input logic opv, input logic [31:0] av, input logic [31:0] bv);
    exp_t e;
    waitIdle($sformatf("op%0d", op_tag));
    start = 1'b1;
    op    = opv;
    a     = av;
    b     = bv;
    predict(opv, av, bv, e);
    sbq.push_back(e);
    op_tag++;
    @(negedge clock);
    start = 1'b0;
    op    = 1'($urandom);
    a     = $urandom;
    b     = $urandom;
  endtask

  task automatic idleWrite(input logic whi, input logic wlo, input logic [31:0] d);
    hi_wr   = whi;
    lo_wr   = wlo;
    wr_data = d;
    if (whi) m_hi = d;
    if (wlo) m_lo = d;
    @(negedge clock);
    hi_wr = 1'b0;
    lo_wr = 1'b0;
    checkOutput("idle_write_hi", hi, m_hi);
    checkOutput("idle_write_lo", lo, m_lo);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      4:       return 32'd0 - 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: every done pulse must match the oldest outstanding operation.
  always @(negedge clock) begin
    if (clear_n && done) begin
      done_cnt++;
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_done: got done=1 at cycle %0d, expected no completion", cyc);
      end else begin
        mon_e = sbq.pop_front();
        checkOutput($sformatf("op%0d_hi", mon_e.tag), hi, mon_e.hi);
        checkOutput($sformatf("op%0d_lo", mon_e.tag), lo, mon_e.lo);
        checkOutput($sformatf("op%0d_div_zero", mon_e.tag), {31'd0, div_zero}, {31'd0, mon_e.dz});
        checkOutput($sformatf("op%0d_done_cycle", mon_e.tag), 32'(cyc), 32'(mon_e.due));
        checkOutput($sformatf("op%0d_busy_at_done", mon_e.tag), {31'd0, busy}, 32'd0);
      end
    end
  end

  initial begin
    int w;
    int saved_done;
    logic [31:0] d1, d2;

    // Reset state
    repeat (3) @(negedge clock);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    checkOutput("reset_div_zero", {31'd0, div_zero}, 32'd0);
    checkOutput("reset_hi", hi, 32'd0);
    checkOutput("reset_lo", lo, 32'd0);
    clear_n = 1'b1;
    @(negedge clock);

    // MUL 7 * -3: busy for MUL_LAT cycles, done for exactly one
    applyStimulus(OP_MUL, 32'd7, 32'hFFFF_FFFD);
    checkOutput("mul_busy_n0", {31'd0, busy}, 32'd1);
    @(negedge clock);
    checkOutput("mul_busy_n1", {31'd0, busy}, 32'd1);
    @(negedge clock);
    checkOutput("mul_busy_n2", {31'd0, busy}, 32'd0);
    @(negedge clock);
    checkOutput("mul_done_one_cycle", {31'd0, done}, 32'd0);

    // Back-to-back: MUL min*min then DIV -7/2 started in the done cycle
    applyStimulus(OP_MUL, 32'h8000_0000, 32'h8000_0000);
    applyStimulus(OP_DIV, 32'hFFFF_FFF9, 32'd2);

    // Zero divisor, then a MUL start clears the sticky flag
    applyStimulus(OP_DIV, 32'd5, 32'd0);
    applyStimulus(OP_MUL, 32'd3, 32'd4);
    checkOutput("div_zero_cleared_by_start", {31'd0, div_zero}, 32'd0);

    // Overflowing divide wraps, no flag
    applyStimulus(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);

    // Direct writes while idle
    waitIdle("pre_write");
    @(negedge clock);
    idleWrite(1'b1, 1'b0, 32'h1234_5678);
    idleWrite(1'b0, 1'b1, 32'h9ABC_DEF0);
    idleWrite(1'b1, 1'b1, $urandom);

    // Writes during a MUL: honoured at E1, lost to the completion at E2
    d1 = 32'hDEAD_BEEF;
    d2 = 32'hCAFE_F00D;
    applyStimulus(OP_MUL, 32'h0001_0003, 32'hFFFF_0005);
    hi_wr   = 1'b1;
    wr_data = d1;
    @(negedge clock);
    hi_wr = 1'b0;
    checkOutput("hi_write_during_mul", hi, d1);
    lo_wr   = 1'b1;
    wr_data = d2;
    @(negedge clock);
    lo_wr = 1'b0;

    // Start while busy is ignored (an accepted one would give a stray done)
    applyStimulus(OP_MUL, 32'd100, 32'd7);
    start = 1'b1;
    op    = OP_MUL;
    a     = 32'd1;
    b     = 32'd1;
    @(negedge clock);
    start = 1'b0;

`ifdef MULDIV_DIV_EN
    // DIV 100/7 with an ignored start at E5 and an HI write at E10
    applyStimulus(OP_DIV, 32'd100, 32'd7);
    repeat (4) @(negedge clock);
    start = 1'b1;
    op    = OP_MUL;
    a     = 32'd1;
    b     = 32'd1;
    @(negedge clock);
    start = 1'b0;
    checkOutput("div_busy_after_ignored_start", {31'd0, busy}, 32'd1);
    repeat (4) @(negedge clock);
    hi_wr   = 1'b1;
    wr_data = 32'h0000_00AA;
    @(negedge clock);
    hi_wr = 1'b0;
    checkOutput("hi_write_during_div", hi, 32'h0000_00AA);

    // Reset at E15 of a DIV aborts it
    applyStimulus(OP_DIV, 32'd1000, 32'd3);
    repeat (14) @(negedge clock);
`else
    // Reset in the middle of a MUL aborts it
    applyStimulus(OP_MUL, 32'd1000, 32'd3);
`endif
    clear_n = 1'b0;
    #1;
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_done", {31'd0, done}, 32'd0);
    checkOutput("abort_hi", hi, 32'd0);
    checkOutput("abort_lo", lo, 32'd0);
    checkOutput("abort_div_zero", {31'd0, div_zero}, 32'd0);
    sbq.delete();
    m_hi = '0;
    m_lo = '0;
    repeat (2) @(negedge clock);
    clear_n = 1'b1;
    saved_done = done_cnt;
    repeat (40) @(negedge clock);
    checkOutput("abort_no_done", 32'(done_cnt), 32'(saved_done));

    // Randomised mix of operations and idle writes
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        waitIdle("rand_write");
        idleWrite(1'($urandom), 1'($urandom), $urandom);
      end
      applyStimulus(1'($urandom), pick(), pick());
    end

    // Drain outstanding operations
    w = 0;
    while (sbq.size() != 0 && w < MAX_WAIT) begin
      @(negedge clock);
      w++;
    end
    checkOutput("scoreboard_drained", 32'(sbq.size()), 32'd0);
    repeat (3) @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_hilo.md
# muldiv_hilo

Sequential multiply/divide controller with its HI/LO result registers, sitting between the ALU operand buses and the datapath's HI/LO consumers. It registers operands and drives them into the existing combinational `mul32` Booth multiplier. It then captures the 64-bit product into HI/LO after a configurable settle latency, or runs a 32-iteration signed divide. Results and status are reported through a start/busy/done handshake.

## Interface
- `MUL_LAT`, 2: cycles from operand capture to HI/LO write for MUL (1..4); gives margin for the combinational multiplier path.
- `clock` in 1: sole clock, rising edge.
- `clear_n` in 1: asynchronous, active-low reset.
- `start` in 1: request; sampled only when `busy`=0.
- `op` in 1: 0=MUL (signed 32x32→64), 1=DIV (signed 32/32).
- `a` in 32: multiplicand / dividend.
- `b` in 32: multiplier / divisor.
- `hi_wr`, `lo_wr` in 1 each: direct register writes (mthi/mtlo).
- `wr_data` in 32: data for `hi_wr`/`lo_wr`.
- `busy` out 1: operation in flight.
- `done` out 1: one-cycle pulse on completion.
- `div_zero` out 1: sticky; set by DIV with `b`=0, cleared by next accepted `start`.
- `hi`, `lo` out 32: HI/LO registers.

## Operation
- States: IDLE, MUL_WAIT, DIV_RUN, DIV_FIX.
- IDLE + `start`: latch `a`, `b`, `op`; clear `div_zero`.
  - MUL → MUL_WAIT, counter=MUL_LAT-1.
  - DIV with `b`≠0 → DIV_RUN; store |a|, |b|, quotient sign (a[31]^b[31]), remainder sign (a[31]); iteration count=32.
  - DIV with `b`=0 → DIV_FIX with zero flag.
- MUL_WAIT: decrement counter. At 0: HI=P[63:32], LO=P[31:0] from `mul32`; → IDLE.
- DIV_RUN: one restoring step per cycle on 32-bit magnitudes (shift remainder left, subtract |b|, set quotient bit if non-negative). After 32 steps → DIV_FIX.
- DIV_FIX: negate quotient/remainder per stored signs; LO=quotient, HI=remainder; → IDLE.
  - Zero divisor: HI=a, LO=0xFFFFFFFF, `div_zero`=1.
  - 0x80000000 / -1: LO=0x80000000 (wraps), HI=0; no flag.
- Remainder takes the sign of the dividend; quotient truncates toward zero.
- `start` while `busy`: ignored, not queued.
- `hi_wr`/`lo_wr`: honoured in any state. A write coinciding with a completion write to the same register loses; completion wins. A write during an operation is later overwritten by completion.
- Operand inputs may change freely after acceptance.

## Timing
- Reset: state=IDLE; `hi`, `lo`=0; `busy`, `done`, `div_zero`=0; iteration and wait counters=0. Reset mid-operation aborts immediately with no HI/LO write.
- Edge E0 accepts `start`; `busy`=1 from E0 until the completion edge.
- MUL: HI/LO written at E(MUL_LAT); `done`=1 and `busy`=0 in the following cycle.
- DIV: steps at E1..E32, fix/write at E33; latency 33. Zero divisor writes at E1.
- `done` is high exactly one cycle. A new `start` in the `done` cycle is accepted, giving back-to-back operation.
- `busy` and `done` are registered outputs.

## Configuration
- `MULDIV_DIV_EN` defined: divider present as above.
- Not defined: no divider logic. DIV goes straight to completion at E1: HI/LO unchanged, `div_zero`=1 (signals unsupported op), `done` pulses normally.

## Structure
- Shared package `muldiv_pkg` holds:
  - op encoding constants `OP_MUL`, `OP_DIV`;
  - state enum;
  - `DIV_STEPS`=32;
  - `DIVZ_QUOT`=32'hFFFFFFFF.
- Sub-module `div32_seq` contains the magnitude iteration datapath (remainder/quotient shift registers, step counter) under `MULDIV_DIV_EN`; the top level owns the FSM, the sign fixup and the `mul32` instance.

## Test plan
- MUL a=7, b=-3 (0xFFFFFFFD), MUL_LAT=2 → after E2: hi=0xFFFFFFFF, lo=0xFFFFFFEB; `done` one cycle; `busy` high two cycles.
- MUL a=b=0x80000000 → hi=0x40000000, lo=0x00000000; immediately followed by DIV a=-7, b=2 in the `done` cycle → at E33: lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV a=5, b=0 → at E1: hi=5, lo=0xFFFFFFFF, `div_zero`=1. Next MUL start clears `div_zero`.
- DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0, `div_zero`=0.
- Start DIV 100/7; pulse `start` (MUL 1×1) at E5 → ignored; assert `hi_wr`=0xAA at E10 → hi=0xAA, then at E33 hi=2, lo=14.
- Start DIV; drop `clear_n` at E15 → `busy`, `hi`, `lo`=0 immediately, no `done`. With `MULDIV_DIV_EN` undefined: DIV leaves hi/lo unchanged, `div_zero`=1, `done` one cycle after E1.
